// File: rtl/bforge_apb_rr_master_if.sv
// Requester and APB signal bundle for bforge_apb_rr_master. The master modport is the arbiter side.
// The slave modport is the requester/target side.
interface bforge_apb_rr_master_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_TGT = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic [NUM_TGT-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_TGT*DATA_W-1:0] prdata;
  logic [NUM_TGT-1:0]        pready;
  logic [NUM_TGT-1:0]        pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/bforge_apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ requesters onto one APB bus decoded to NUM_TGT targets.
// It issues one transfer at a time, with a decode-miss response and a PREADY timeout abort.
module bforge_apb_rr_master #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_TGT  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WIN_LOG2 = 12,
  parameter int TIMEOUT  = 16
) (
  input  logic                   pclk,
  input  logic                   preset,
  bforge_apb_rr_master_if.master bus
);
  localparam int RW = $clog2(NUM_REQ);
  localparam int TW = $clog2(NUM_TGT);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HI = WIN_LOG2 + TW;
  localparam logic [NUM_REQ-1:0] ONE_R = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_TGT-1:0] ONE_T = {{(NUM_TGT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q;
  logic [RW-1:0]       ptr_q, gnt_q, gnt_d, idx;
  logic [TW-1:0]       tgt_q, tgt_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [NUM_TGT-1:0]  psel_q;
  logic                penable_q, err_q, any_vld, miss_d;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [CW-1:0]       cnt_q;

  logic [ADDR_W-1:0]   req_addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   req_wdata_a [NUM_REQ];
  logic [DATA_W-1:0]   prdata_a    [NUM_TGT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_addr_a[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign req_wdata_a[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < NUM_TGT; gi++) begin : g_tgt
      assign prdata_a[gi] = bus.prdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan from the highest offset down so the last hit is the first valid at/after ptr_q.
  always_comb begin
    gnt_d   = '0;
    any_vld = 1'b0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = RW'((int'(ptr_q) + i) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        gnt_d   = idx;
        any_vld = 1'b1;
      end
    end
  end

  assign addr_d = req_addr_a[gnt_d];
  assign tgt_d  = addr_d[WIN_LOG2 +: TW];
  assign miss_d = (addr_d >> HI) != '0;

  assign bus.req_ready = (state_q == IDLE && any_vld) ? (ONE_R << gnt_d) : '0;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = wr_q;
  assign bus.paddr     = addr_q;
  assign bus.pwdata    = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      tgt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_vld) begin
            gnt_q <= gnt_d;
            if (miss_d) begin
              rsp_valid_q <= ONE_R << gnt_d;
              err_q       <= 1'b1;
              rdata_q     <= '0;
              state_q     <= RESP;
            end else begin
              tgt_q   <= tgt_d;
              wr_q    <= bus.req_write[gnt_d];
              addr_q  <= addr_d;
              wdata_q <= req_wdata_a[gnt_d];
              psel_q  <= ONE_T << tgt_d;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= CW'(1);
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready[tgt_q]) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= ONE_R << gnt_q;
            err_q       <= bus.pslverr[tgt_q];
            rdata_q     <= wr_q ? '0 : prdata_a[tgt_q];
            state_q     <= RESP;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= ONE_R << gnt_q;
            err_q       <= 1'b1;
            rdata_q     <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          ptr_q   <= (gnt_q == RW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          err_q   <= 1'b0;
          rdata_q <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
